// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES-128 key schedule.
package aes_pkg;

    typedef logic [31:0] word_t;
    typedef logic [7:0]  byte_t;

    localparam int NB = 4;
    localparam int NR = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        EMIT = 2'd2
    } state_t;

    localparam byte_t RCON [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box; four instances form SubWord.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    localparam byte_t SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/aes_key_schedule.sv
// Sequential AES-128 key expansion: streams w0..w43 one column per handshake.
// Macro AES_KEYSCHED_REVERSE_EN adds a word store and reverse (round 10..0) streaming.
module aes_key_schedule #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key,
    input  logic         rev,
    output logic         busy,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   col_out0,
    output logic [7:0]   col_out1,
    output logic [7:0]   col_out2,
    output logic [7:0]   col_out3,
    output logic [3:0]   round_idx,
    output logic [1:0]   word_idx,
    output logic         last
);
    import aes_pkg::*;

    localparam int         WORDS    = NB * (NR + 1);
    localparam logic [5:0] LAST_IDX = 6'(WORDS - 1);
    localparam logic [5:0] GEN_END  = 6'(WORDS - NB);

    state_t     r_state;
    word_t      r_win [0:3];
    logic [5:0] r_i;
    byte_t      r_rcon;
    word_t      r_out;
    logic       r_valid;
    logic       r_busy;
    logic       r_last;
    logic [3:0] r_round;
    logic [1:0] r_word;

    word_t      w_rot;
    word_t      w_sub;
    word_t      w_next;
    logic [5:0] w_i_inc;
    logic       w_more;

    assign w_rot = {r_win[3][23:0], r_win[3][31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (
            .i_byte (w_rot[8*g +: 8]),
            .o_byte (w_sub[8*g +: 8])
        );
    end

    // Expansion step: w[i+4] from the window w[i..i+3]; column 0 of a round takes the S-box path.
    always_comb begin
        w_i_inc = r_i + 6'd1;
        w_more  = (r_i < GEN_END);
        if (r_i[1:0] == 2'd0) begin
            w_next = r_win[0] ^ w_sub ^ {r_rcon, 24'h000000};
        end else begin
            w_next = r_win[0] ^ r_win[3];
        end
    end

`ifdef AES_KEYSCHED_REVERSE_EN
    word_t      r_mem [0:WORDS-1];
    logic       r_rev;
    logic [5:0] w_i_rev;
    logic [5:0] w_i_fill;

    // Reverse walk: columns ascend within a round, then step to column 0 of the round below.
    always_comb begin
        w_i_fill = r_i + 6'd4;
        if (r_i[1:0] == 2'd3) begin
            w_i_rev = r_i - 6'd7;
        end else begin
            w_i_rev = r_i + 6'd1;
        end
    end

    // Word store: key words on a reverse start, then one generated word per FILL cycle.
    always_ff @(posedge clk) begin
        if ((r_state == IDLE) && start && rev) begin
            r_mem[0] <= key[127:96];
            r_mem[1] <= key[95:64];
            r_mem[2] <= key[63:32];
            r_mem[3] <= key[31:0];
        end else if ((r_state == FILL) && w_more) begin
            r_mem[w_i_fill] <= w_next;
        end
    end
`else
    logic w_unused_rev;
    assign w_unused_rev = rev;
`endif

    // Control FSM with key window, counters and registered stream outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            for (int k = 0; k < 4; k++) begin
                r_win[k] <= '0;
            end
            r_i     <= 6'd0;
            r_rcon  <= 8'h01;
            r_out   <= 32'h0000_0000;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_last  <= 1'b0;
            r_round <= 4'd0;
            r_word  <= 2'd0;
`ifdef AES_KEYSCHED_REVERSE_EN
            r_rev   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_win[0] <= key[127:96];
                        r_win[1] <= key[95:64];
                        r_win[2] <= key[63:32];
                        r_win[3] <= key[31:0];
                        r_i      <= 6'd0;
                        r_rcon   <= 8'h01;
                        r_busy   <= 1'b1;
                        r_round  <= 4'd0;
                        r_word   <= 2'd0;
                        r_last   <= 1'b0;
`ifdef AES_KEYSCHED_REVERSE_EN
                        r_rev <= rev;
                        if (rev) begin
                            r_state <= FILL;
                            r_valid <= 1'b0;
                        end else begin
                            r_state <= EMIT;
                            r_valid <= 1'b1;
                            r_out   <= key[127:96];
                        end
`else
                        r_state <= EMIT;
                        r_valid <= 1'b1;
                        r_out   <= key[127:96];
`endif
                    end
                end
`ifdef AES_KEYSCHED_REVERSE_EN
                FILL: begin
                    if (!w_more) begin
                        r_state <= EMIT;
                        r_valid <= 1'b1;
                        r_i     <= GEN_END;
                        r_out   <= r_mem[GEN_END];
                        r_round <= GEN_END[5:2];
                        r_word  <= 2'd0;
                        r_last  <= 1'b0;
                    end else begin
                        r_win[0] <= r_win[1];
                        r_win[1] <= r_win[2];
                        r_win[2] <= r_win[3];
                        r_win[3] <= w_next;
                        if (r_i[1:0] == 2'd0) begin
                            r_rcon <= xtime(r_rcon);
                        end
                        r_i <= w_i_inc;
                    end
                end
`endif
                EMIT: begin
                    if (out_ready) begin
                        if (r_last) begin
                            r_state <= IDLE;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_last  <= 1'b0;
`ifdef AES_KEYSCHED_REVERSE_EN
                        end else if (r_rev) begin
                            r_out   <= r_mem[w_i_rev];
                            r_i     <= w_i_rev;
                            r_round <= w_i_rev[5:2];
                            r_word  <= w_i_rev[1:0];
                            r_last  <= (w_i_rev == 6'd3);
`endif
                        end else begin
                            r_win[0] <= r_win[1];
                            r_win[1] <= r_win[2];
                            r_win[2] <= r_win[3];
                            // Nothing beyond w43 is generated; the tail of the window drains with zeros.
                            if (w_more) begin
                                r_win[3] <= w_next;
                                if (r_i[1:0] == 2'd0) begin
                                    r_rcon <= xtime(r_rcon);
                                end
                            end else begin
                                r_win[3] <= 32'h0000_0000;
                            end
                            r_out   <= r_win[1];
                            r_i     <= w_i_inc;
                            r_round <= w_i_inc[5:2];
                            r_word  <= w_i_inc[1:0];
                            r_last  <= (w_i_inc == LAST_IDX);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_last  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign out_valid = r_valid;
    assign last      = r_last;
    assign col_out0  = r_out[31:24];
    assign col_out1  = r_out[23:16];
    assign col_out2  = r_out[15:8];
    assign col_out3  = r_out[7:0];
    assign round_idx = r_round;
    assign word_idx  = r_word;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Scoreboard bench for aes_key_schedule against a GF(2^8)-derived key expansion model.
module tb_aes_key_schedule;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key;
    logic         rev;
    logic         busy;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   col_out0, col_out1, col_out2, col_out3;
    logic [3:0]   round_idx;
    logic [1:0]   word_idx;
    logic         last;
    logic [31:0]  dut_w;

    localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    always #5 clk = ~clk;

    aes_key_schedule #(.NR(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key       (key),
        .rev       (rev),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .col_out0  (col_out0),
        .col_out1  (col_out1),
        .col_out2  (col_out2),
        .col_out3  (col_out3),
        .round_idx (round_idx),
        .word_idx  (word_idx),
        .last      (last)
    );

    assign dut_w = {col_out0, col_out1, col_out2, col_out3};

    typedef struct {
        logic [31:0] w;
        logic [3:0]  r;
        logic [1:0]  c;
        logic        l;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] got_q[$];
    logic [31:0] model_w [44];
    logic [7:0]  sbox_m [256];
    int          checks = 0;
    int          failures = 0;
    bit          ready_rand = 1'b0;

    // Reference model: S-box from GF inverse + affine map, expansion over a plain word array.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] t;
        t = {v, v} << n;
        return t[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand(input logic [127:0] k);
        logic [7:0]  rc;
        logic [31:0] t;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) model_w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = model_w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            model_w[i] = model_w[i-4] ^ t;
        end
    endtask

    task automatic push_expected(input logic [127:0] k, input logic r);
        exp_t e;
        logic eff;
        expand(k);
`ifdef AES_KEYSCHED_REVERSE_EN
        eff = r;
`else
        eff = 1'b0;
`endif
        if (eff) begin
            for (int rd = 10; rd >= 0; rd--) begin
                for (int c = 0; c < 4; c++) begin
                    e.w = model_w[4*rd + c]; e.r = 4'(rd); e.c = 2'(c); e.l = (rd == 0 && c == 3);
                    exp_q.push_back(e);
                end
            end
        end else begin
            for (int i = 0; i < 44; i++) begin
                e.w = model_w[i]; e.r = 4'(i / 4); e.c = 2'(i % 4); e.l = (i == 43);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    // Monitor: pops the scoreboard on each transfer and checks stall stability.
    exp_t        mon_e;
    bit          stalled = 1'b0;
    logic [31:0] snap_w;
    logic [3:0]  snap_r;
    logic [1:0]  snap_c;
    logic        snap_l;

    always @(negedge clk) begin
        if (rst) begin
            stalled <= 1'b0;
        end else begin
            if (stalled) begin
                checks++;
                if (!out_valid || dut_w !== snap_w || round_idx !== snap_r || word_idx !== snap_c || last !== snap_l) begin
                    failures++;
                    $display("FAIL stall_hold got v=%0b w=%h r=%0d c=%0d l=%0b required v=1 w=%h r=%0d c=%0d l=%0b",
                             out_valid, dut_w, round_idx, word_idx, last, snap_w, snap_r, snap_c, snap_l);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected got w=%h r=%0d c=%0d required no transfer", dut_w, round_idx, word_idx);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (dut_w !== mon_e.w || round_idx !== mon_e.r || word_idx !== mon_e.c || last !== mon_e.l) begin
                        failures++;
                        $display("FAIL scoreboard n=%0d got w=%h r=%0d c=%0d l=%0b required w=%h r=%0d c=%0d l=%0b",
                                 got_q.size(), dut_w, round_idx, word_idx, last, mon_e.w, mon_e.r, mon_e.c, mon_e.l);
                    end
                end
                got_q.push_back(dut_w);
            end
            stalled <= out_valid && !out_ready;
            snap_w  <= dut_w;
            snap_r  <= round_idx;
            snap_c  <= word_idx;
            snap_l  <= last;
        end
    end

    // Consumer ready: held high, or a fair coin per cycle when backpressure is enabled.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic issue_start(input logic [127:0] k, input logic r);
        @(posedge clk);
        #1;
        start = 1'b1; key = k; rev = r;
        push_expected(k, r);
        @(posedge clk);
        #1;
        start = 1'b0; rev = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy || exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout got busy=%0b pending=%0d required busy=0 pending=0", name, busy, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
        chk({name, "_idle_valid"}, 32'(out_valid), 32'd0);
    endtask

    task automatic wait_words(input int n, input string name);
        int t;
        t = 0;
        while (got_q.size() < n && t < 500) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (got_q.size() < n) begin
            failures++;
            $display("FAIL %s got=%0d words required=%0d", name, got_q.size(), n);
        end
    endtask

    initial begin
        int           gaps;
        logic [127:0] rk;
        logic         rr;

        rst = 1'b1; start = 1'b0; key = '0; rev = 1'b0;
        build_sbox();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_last", 32'(last), 32'd0);
        chk("rst_col", dut_w, 32'd0);
        chk("rst_round", 32'(round_idx), 32'd0);
        chk("rst_word", 32'(word_idx), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // FIPS-197 A.1 at full throughput.
        got_q.delete(); ready_rand = 1'b0;
        issue_start(KEY_A1, 1'b0);
        chk("a1_lat_valid", 32'(out_valid), 32'd1);
        chk("a1_lat_busy", 32'(busy), 32'd1);
        gaps = 0;
        for (int j = 0; j < 44; j++) begin
            if (!out_valid) gaps++;
            @(posedge clk);
            #1;
        end
        chk("a1_valid_gaps", 32'(gaps), 32'd0);
        chk("a1_valid_drop", 32'(out_valid), 32'd0);
        chk("a1_busy_drop", 32'(busy), 32'd0);
        chk("a1_count", 32'(got_q.size()), 32'd44);
        chk("a1_w0", got_q[0], 32'h2b7e1516);
        chk("a1_w4", got_q[4], 32'ha0fafe17);
        chk("a1_w5", got_q[5], 32'h88542cb1);
        chk("a1_w40", got_q[40], 32'hd014f9a8);
        chk("a1_w43", got_q[43], 32'hb6630ca6);
        wait_done("a1");

        // All-zero key.
        got_q.delete();
        issue_start(128'h0, 1'b0);
        wait_done("zero");
        chk("zero_w4", got_q[4], 32'h62636363);
        chk("zero_w40", got_q[40], 32'hb4ef5bcb);
        chk("zero_w43", got_q[43], 32'h6f8f188e);

        // A.1 under random backpressure.
        got_q.delete(); ready_rand = 1'b1;
        issue_start(KEY_A1, 1'b0);
        wait_done("bp");
        chk("bp_count", 32'(got_q.size()), 32'd44);
        chk("bp_w43", got_q[43], 32'hb6630ca6);
        ready_rand = 1'b0;

        // Second start while busy must be ignored.
        got_q.delete();
        issue_start(KEY_A1, 1'b0);
        wait_words(10, "busy_reach");
        @(posedge clk);
        #1;
        start = 1'b1; key = 128'h00112233445566778899aabbccddeeff;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("busy_start");
        chk("busy_start_count", 32'(got_q.size()), 32'd44);
        chk("busy_start_w43", got_q[43], 32'hb6630ca6);

        // Asynchronous reset in the middle of a stream.
        got_q.delete();
        rk = {$urandom, $urandom, $urandom, $urandom};
        issue_start(rk, 1'b0);
        wait_words(20, "mid_reach");
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_col", dut_w, 32'd0);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        got_q.delete();
        rk = {$urandom, $urandom, $urandom, $urandom};
        issue_start(rk, 1'b0);
        chk("mid_fresh_w0", dut_w, rk[127:96]);
        wait_done("mid_fresh");

        // Random keys, random rev request, random backpressure.
        for (int n = 0; n < 4; n++) begin
            got_q.delete();
            ready_rand = 1'b1;
            rk = {$urandom, $urandom, $urandom, $urandom};
            rr = 1'($urandom_range(0, 1));
            issue_start(rk, rr);
            wait_done("rand");
            chk("rand_count", 32'(got_q.size()), 32'd44);
        end
        ready_rand = 1'b0;

`ifdef AES_KEYSCHED_REVERSE_EN
        // Reverse stream of the A.1 key.
        got_q.delete();
        issue_start(KEY_A1, 1'b1);
        gaps = 0;
        for (int j = 0; j < 41; j++) begin
            if (out_valid || !busy) gaps++;
            @(posedge clk);
            #1;
        end
        chk("rev_fill_hold", 32'(gaps), 32'd0);
        chk("rev_valid_rise", 32'(out_valid), 32'd1);
        chk("rev_first_round", 32'(round_idx), 32'd10);
        wait_done("rev");
        chk("rev_w0", got_q[0], 32'hd014f9a8);
        chk("rev_w1", got_q[1], 32'hc9ee2589);
        chk("rev_w2", got_q[2], 32'he13f0cc8);
        chk("rev_w3", got_q[3], 32'hb6630ca6);
        chk("rev_final", got_q[43], 32'h09cf4f3c);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
